vga_scan_timer: RTL

//  Free-running VGA raster timer for 640x480@60. Drives the VGA sync pins and the scan strobes

---
 rtl/vga_scan_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_scan_timer.sv
// Free-running 640x480@60 VGA raster timer: sync pins plus scan strobes for pixel_generator.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit o_frame_count that steps on every frame start.
module vga_scan_timer #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   CELL_W    = 21,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_visible,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_line_reset,
  output logic       o_screen_reset,
  output logic       o_vblank_start,
  output logic       o_cell_tick,
  output logic       o_line_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] o_frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int CELL_CW = $clog2(CELL_W + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]         H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]         V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]         H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]         V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]         HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]         HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]         VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]         VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CELL_CW-1:0] CELL_LAST = CELL_CW'(CELL_W - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         h_q, h_d;
  logic [9:0]         v_q, v_d;
  logic [CELL_CW-1:0] cell_q, cell_d;
  logic               pe;
  logic               vis_d;
  logic               hsync_on_d;
  logic               vsync_on_d;

  // Everything below is decoded on the position the next pixel enable moves to,
  // so the registered outputs line up with the registered (h,v).
  always_comb begin
    pe    = (div_q == DIV_LAST);
    div_d = pe ? '0 : div_q + DIV_W'(1);

    h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    cell_d     = ((h_d == '0) || (cell_q == CELL_LAST)) ? '0 : cell_q + CELL_CW'(1);
    vis_d      = (h_d < H_VIS) && (v_d < V_VIS);
    hsync_on_d = (h_d >= HS_START) && (h_d < HS_END);
    vsync_on_d = (v_d >= VS_START) && (v_d < VS_END);
  end

  // Starting at the last position makes the first pixel enable after reset land on (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q          <= '0;
      h_q            <= H_LAST;
      v_q            <= V_LAST;
      cell_q         <= '0;
      o_hsync        <= ~SYNC_POL;
      o_vsync        <= ~SYNC_POL;
      o_visible      <= 1'b0;
      o_x            <= '0;
      o_y            <= '0;
      o_line_reset   <= 1'b0;
      o_screen_reset <= 1'b0;
      o_vblank_start <= 1'b0;
      o_cell_tick    <= 1'b0;
      o_line_tick    <= 1'b0;
    end else begin
      div_q          <= div_d;
      o_line_reset   <= 1'b0;
      o_screen_reset <= 1'b0;
      o_vblank_start <= 1'b0;
      o_cell_tick    <= 1'b0;
      o_line_tick    <= 1'b0;
      if (pe) begin
        h_q            <= h_d;
        v_q            <= v_d;
        cell_q         <= cell_d;
        o_hsync        <= hsync_on_d ? SYNC_POL : ~SYNC_POL;
        o_vsync        <= vsync_on_d ? SYNC_POL : ~SYNC_POL;
        o_visible      <= vis_d;
        o_x            <= h_d;
        o_y            <= v_d;
        o_line_reset   <= (h_d == '0);
        o_screen_reset <= (h_d == '0) && (v_d == '0);
        o_vblank_start <= (h_d == '0) && (v_d == V_VIS);
        o_cell_tick    <= vis_d && (cell_d == CELL_LAST);
        o_line_tick    <= (h_d == H_VIS) && (v_d < V_VIS);
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
    end else if (pe && (h_d == '0) && (v_d == '0)) begin
      o_frame_count <= o_frame_count + 8'd1;
    end
  end
`endif

endmodule
